pad_ctrl_bank: RTL and testbench

PAD_CTRL_BANK -- requirements
Module: pad_ctrl_bank

---
 rtl/pad_ctrl_bank.sv | 131 +++++++++++++
 tb/tb_pad_ctrl_bank.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pad_ctrl_bank.sv
// Bank of configurable I/O pad channels: registered output drivers, synchronised
// and glitch-filtered inputs, and per-channel edge interrupts with a shared start-up FSM.
module pad_ctrl_bank #(
   parameter int unsigned NCH         = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_W      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    cfg_oen,
   input  logic [NCH-1:0]    cfg_out,
   input  logic [NCH-1:0]    cfg_od,
   input  logic [NCH-1:0]    cfg_filt_en,
   input  logic [FILT_W-1:0] filt_len,
   input  logic [NCH-1:0]    irq_rise_en,
   input  logic [NCH-1:0]    irq_fall_en,
   input  logic [NCH-1:0]    irq_clr,
   input  logic [NCH-1:0]    pad_o,
   output logic [NCH-1:0]    pad_oen,
   output logic [NCH-1:0]    pad_i,
   output logic [NCH-1:0]    in_val,
   output logic [NCH-1:0]    irq_pend,
   output logic              irq
);

   localparam int unsigned IW = $clog2(SYNC_STAGES + 1);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [IW-1:0]     init_cnt_q;
   logic [NCH-1:0]    sync_q [SYNC_STAGES];
   logic [NCH-1:0]    s;
   logic [FILT_W-1:0] cnt_q [NCH];
   logic [FILT_W-1:0] cnt_d [NCH];
   logic [NCH-1:0]    in_val_d;
   logic [NCH-1:0]    accept;
   logic [NCH-1:0]    rise_q, fall_q;

   // Bank state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_INIT;
      else     state_q <= state_d;
   end

   // INIT lasts SYNC_STAGES+1 cycles so the sync chains are flushed before edges count
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: if (init_cnt_q == IW'(SYNC_STAGES)) state_d = ST_RUN;
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     init_cnt_q <= '0;
      else if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + IW'(1);
   end

   // Output driver registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pad_oen <= '1;
         pad_i   <= '0;
      end else begin
         pad_oen <= cfg_oen | (cfg_od & cfg_out);
         pad_i   <= ~cfg_oen & ~cfg_od & cfg_out;
      end
   end

   // Input synchroniser chains
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= pad_o;
         for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Glitch filter: accept a change once it has persisted past filt_len cycles
   always_comb begin
      in_val_d = in_val;
      accept   = '0;
      for (int i = 0; i < int'(NCH); i++) cnt_d[i] = cnt_q[i];
      for (int i = 0; i < int'(NCH); i++) begin
         if (state_q == ST_INIT) begin
            in_val_d[i] = s[i];
            cnt_d[i]    = '0;
         end else if (s[i] == in_val[i]) begin
            cnt_d[i] = '0;
         end else if (!cfg_filt_en[i] || (cnt_q[i] >= filt_len)) begin
            in_val_d[i] = s[i];
            cnt_d[i]    = '0;
            accept[i]   = 1'b1;
         end else begin
            cnt_d[i] = cnt_q[i] + FILT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_val <= '0;
         for (int i = 0; i < int'(NCH); i++) cnt_q[i] <= '0;
      end else begin
         in_val <= in_val_d;
         for (int i = 0; i < int'(NCH); i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Edge events are only produced by RUN-state acceptances, so INIT never raises an interrupt
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rise_q   <= '0;
         fall_q   <= '0;
         irq_pend <= '0;
      end else begin
         rise_q   <= accept & s;
         fall_q   <= accept & ~s;
         irq_pend <= (irq_pend & ~irq_clr) | (rise_q & irq_rise_en) | (fall_q & irq_fall_en);
      end
   end

   assign irq = |irq_pend;

endmodule

// File: tb/tb_pad_ctrl_bank.sv
// Directed self-checking bench for pad_ctrl_bank (NCH=8, SYNC_STAGES=2, FILT_W=4).
module tb_pad_ctrl_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] cfg_oen, cfg_out, cfg_od, cfg_filt_en;
   logic [3:0] filt_len;
   logic [7:0] irq_rise_en, irq_fall_en, irq_clr, pad_o;
   logic [7:0] pad_oen, pad_i, in_val, irq_pend;
   logic       irq;

   int ncmp  = 0;
   int nfail = 0;

   pad_ctrl_bank #(.NCH(8), .SYNC_STAGES(2), .FILT_W(4)) dut (
      .clk(clk), .rst(rst),
      .cfg_oen(cfg_oen), .cfg_out(cfg_out), .cfg_od(cfg_od), .cfg_filt_en(cfg_filt_en),
      .filt_len(filt_len), .irq_rise_en(irq_rise_en), .irq_fall_en(irq_fall_en),
      .irq_clr(irq_clr), .pad_o(pad_o),
      .pad_oen(pad_oen), .pad_i(pad_i), .in_val(in_val), .irq_pend(irq_pend), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      cfg_oen = 8'hFF; cfg_out = 8'h00; cfg_od = 8'h00; cfg_filt_en = 8'h00;
      filt_len = 4'd0; irq_rise_en = 8'hFF; irq_fall_en = 8'h00; irq_clr = 8'h00;
      pad_o = 8'h01;

      // reset values
      #2;
      check("rst_pad_oen", 32'(pad_oen), 32'hFF);
      check("rst_pad_i", 32'(pad_i), 32'h00);
      check("rst_in_val", 32'(in_val), 32'h00);
      check("rst_irq_pend", 32'(irq_pend), 32'h00);
      check("rst_irq", 32'(irq), 32'h0);
      tick(2);
      rst = 1'b0;

      // INIT: pad_o[0]=1 propagates without an interrupt
      tick(2);
      check("init_in_val_c2", 32'(in_val), 32'h00);
      tick(1);
      check("init_in_val_c3", 32'(in_val), 32'h01);
      tick(3);
      check("init_no_pend", 32'(irq_pend), 32'h00);
      check("init_no_irq", 32'(irq), 32'h0);

      // channel 1 output modes
      cfg_oen[1] = 1'b0; cfg_out[1] = 1'b1;
      #1;
      check("pp_latency_oen", 32'(pad_oen), 32'hFF);
      tick(1);
      check("pp_oen", 32'(pad_oen), 32'hFD);
      check("pp_i", 32'(pad_i), 32'h02);
      cfg_od[1] = 1'b1;
      tick(1);
      check("od_hi_oen", 32'(pad_oen), 32'hFF);
      check("od_hi_i", 32'(pad_i), 32'h00);
      cfg_out[1] = 1'b0;
      tick(1);
      check("od_lo_oen", 32'(pad_oen), 32'hFD);
      check("od_lo_i", 32'(pad_i), 32'h00);

      // channel 2 filter: 3-cycle pulse rejected
      filt_len = 4'd3; cfg_filt_en[2] = 1'b1;
      pad_o[2] = 1'b1;
      tick(3);
      pad_o[2] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check("filt_short", 32'(in_val[2]), 32'h0);
      end
      // 4-cycle pulse accepted 6 cycles after its start
      pad_o[2] = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick(1);
         check("filt_long_wait", 32'(in_val[2]), 32'h0);
      end
      pad_o[2] = 1'b0;
      tick(1);
      check("filt_long_wait5", 32'(in_val[2]), 32'h0);
      check("filt_no_pend_yet", 32'(irq_pend), 32'h00);
      tick(1);
      check("filt_long_accept", 32'(in_val[2]), 32'h1);
      tick(1);
      check("rise_pend", 32'(irq_pend), 32'h04);
      check("rise_irq", 32'(irq), 32'h1);
      irq_clr = 8'h04;
      tick(1);
      irq_clr = 8'h00;
      check("clr_pend", 32'(irq_pend), 32'h00);
      tick(4);
      check("filt_fall_back", 32'(in_val[2]), 32'h0);
      check("fall_masked", 32'(irq_pend), 32'h00);

      // channel 3 fall interrupt, enable gating and set-beats-clear
      irq_rise_en = 8'h00; irq_fall_en = 8'h08;
      pad_o[3] = 1'b1;
      tick(5);
      check("ch3_high", 32'(in_val[3]), 32'h1);
      check("ch3_rise_masked", 32'(irq_pend), 32'h00);
      pad_o[3] = 1'b0;
      tick(3);
      check("ch3_fall_in", 32'(in_val[3]), 32'h0);
      check("ch3_pend_wait", 32'(irq_pend), 32'h00);
      tick(1);
      check("ch3_fall_pend", 32'(irq_pend), 32'h08);
      check("ch3_fall_irq", 32'(irq), 32'h1);
      irq_fall_en = 8'h00;
      tick(1);
      check("en_clear_keeps", 32'(irq_pend), 32'h08);
      irq_fall_en = 8'h08;
      pad_o[3] = 1'b1;
      tick(3);
      check("ch3_high2", 32'(in_val[3]), 32'h1);
      pad_o[3] = 1'b0;
      tick(3);
      irq_clr = 8'h08;
      tick(1);
      irq_clr = 8'h00;
      check("set_wins", 32'(irq_pend), 32'h08);
      irq_clr = 8'h08;
      tick(1);
      irq_clr = 8'h00;
      check("clr_only", 32'(irq_pend), 32'h00);
      check("clr_irq", 32'(irq), 32'h0);

      // channel 4: shrinking filt_len mid-count accepts on the next cycle
      filt_len = 4'd7; cfg_filt_en[4] = 1'b1;
      pad_o[4] = 1'b1;
      tick(7);
      check("shrink_before", 32'(in_val[4]), 32'h0);
      filt_len = 4'd2;
      tick(1);
      check("shrink_accept", 32'(in_val[4]), 32'h1);

      // all channels pending, then reset mid-filter
      tick(3);
      cfg_filt_en = 8'h00; irq_rise_en = 8'hFF; irq_fall_en = 8'hFF;
      pad_o = ~pad_o;
      tick(5);
      check("all_pend", 32'(irq_pend), 32'hFF);
      check("all_in_val", 32'(in_val), 32'hEE);
      cfg_filt_en = 8'hFF; filt_len = 4'd15;
      pad_o = ~pad_o;
      tick(5);
      check("mid_in_val", 32'(in_val), 32'hEE);
      check("mid_pad_oen", 32'(pad_oen), 32'hFD);
      #2 rst = 1'b1;
      #1;
      check("async_pad_oen", 32'(pad_oen), 32'hFF);
      check("async_pad_i", 32'(pad_i), 32'h00);
      check("async_in_val", 32'(in_val), 32'h00);
      check("async_pend", 32'(irq_pend), 32'h00);
      check("async_irq", 32'(irq), 32'h0);
      tick(2);
      cfg_filt_en = 8'h00;
      rst = 1'b0;
      tick(2);
      check("reinit_c2", 32'(in_val), 32'h00);
      tick(1);
      check("reinit_c3", 32'(in_val), 32'h11);
      tick(4);
      check("reinit_no_pend", 32'(irq_pend), 32'h00);
      check("reinit_pad_oen", 32'(pad_oen), 32'hFD);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
